// File: rtl/bsg_irq_to_axil_pkg.sv
// Shared types and constants for the interrupt-to-AXI-Lite notifier.
package bsg_irq_to_axil_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_send = 2'd1,
        e_resp = 2'd2
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Index width that stays at least one bit for single-entry vectors.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_irq_to_axil_notifier_if.sv
// AXI4-Lite bundle used by the notifier; master drives AW/W/B-ready and the tied-off read side.
interface bsg_irq_to_axil_notifier_if #(
    parameter int unsigned axil_addr_width_p = 32,
    parameter int unsigned axil_data_width_p = 32
);
    logic [axil_addr_width_p-1:0]   awaddr;
    logic [2:0]                     awprot;
    logic                           awvalid;
    logic                           awready;
    logic [axil_data_width_p-1:0]   wdata;
    logic [axil_data_width_p/8-1:0] wstrb;
    logic                           wvalid;
    logic                           wready;
    logic [1:0]                     bresp;
    logic                           bvalid;
    logic                           bready;
    logic [axil_addr_width_p-1:0]   araddr;
    logic [2:0]                     arprot;
    logic                           arvalid;
    logic                           arready;
    logic [axil_data_width_p-1:0]   rdata;
    logic [1:0]                     rresp;
    logic                           rvalid;
    logic                           rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/bsg_irq_pending_tracker.sv
// One interrupt source: input register, edge/level detect, re-arm holdoff and sticky pending bit.
module bsg_irq_pending_tracker
    import bsg_irq_to_axil_pkg::*;
#(
    parameter bit          edge_p           = 1'b1,
    parameter int unsigned holdoff_cycles_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic irq_i,
    input  logic en_i,
    input  logic in_flight_i,
    input  logic clr_i,
    input  logic load_holdoff_i,
    output logic pending_o
);
    localparam int unsigned hold_w_lp = safe_clog2(holdoff_cycles_p + 1);

    logic                 irq_q, irq_prev_q;
    logic                 pending_q, pending_d;
    logic                 set;
    logic [hold_w_lp-1:0] holdoff_q, holdoff_d;

    always_comb begin
        if (edge_p) set = en_i & irq_q & ~irq_prev_q;
        else        set = en_i & irq_q & ~in_flight_i & (holdoff_q == '0);
        // A new event on the acknowledge cycle must survive the clear.
        pending_d = en_i & ((pending_q & ~clr_i) | set);
        if (load_holdoff_i)         holdoff_d = hold_w_lp'(holdoff_cycles_p);
        else if (holdoff_q != '0)   holdoff_d = holdoff_q - 1'b1;
        else                        holdoff_d = holdoff_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            irq_q      <= 1'b0;
            irq_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            holdoff_q  <= '0;
        end else begin
            irq_q      <= irq_i;
            irq_prev_q <= irq_q;
            pending_q  <= pending_d;
            holdoff_q  <= holdoff_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/bsg_irq_to_axil_notifier.sv
// Interrupt lines to AXI4-Lite doorbell writes with round-robin service and bounded retry.
// Optional BSG_IRQ_TO_AXIL_SEQ_EN places a 16-bit completion sequence number in wdata[31:16].
module bsg_irq_to_axil_notifier
    import bsg_irq_to_axil_pkg::*;
#(
    parameter int unsigned axil_data_width_p = 32,
    parameter int unsigned axil_addr_width_p = 32,
    parameter int unsigned irq_sources_p     = 8,
    parameter logic [axil_addr_width_p-1:0] irq_base_addr_p = '0,
    parameter int unsigned irq_stride_p      = 4,
    parameter logic [irq_sources_p-1:0] edge_mask_p = '1,
    parameter int unsigned holdoff_cycles_p  = 16,
    parameter int unsigned max_retries_p     = 3
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [irq_sources_p-1:0]                irq_i,
    input  logic [irq_sources_p-1:0]                irq_en_i,
    output logic [irq_sources_p-1:0]                pending_o,
    output logic                                    busy_o,
    output logic                                    err_v_o,
    output logic [safe_clog2(irq_sources_p)-1:0]    err_id_o,
    bsg_irq_to_axil_notifier_if.master              m_axil
);
    localparam int unsigned id_w_lp    = safe_clog2(irq_sources_p);
    localparam int unsigned retry_w_lp = safe_clog2(max_retries_p + 1);

    state_e                         state_q;
    logic [id_w_lp-1:0]             id_q, last_q, pick_id;
    logic [retry_w_lp-1:0]          retry_q;
    logic                           awvalid_q, wvalid_q, bready_q, err_v_q;
    logic [id_w_lp-1:0]             err_id_q;
    logic [axil_addr_width_p-1:0]   awaddr_q, pick_addr;
    logic [axil_data_width_p-1:0]   wdata_q, pick_data;
    logic [irq_sources_p-1:0]       pending, clr_v, hold_v, inflight_v;
    logic                           pick_v, busy, b_hs, resp_ok, retry_left;
    logic                           done_ok, done_drop, send_done;

    assign busy       = (state_q != e_idle);
    assign b_hs       = (state_q == e_resp) & bready_q & m_axil.bvalid;
    assign resp_ok    = (m_axil.bresp == OKAY) | (m_axil.bresp == EXOKAY);
    assign retry_left = (retry_q < retry_w_lp'(max_retries_p));
    assign done_ok    = b_hs & resp_ok;
    assign done_drop  = b_hs & ~resp_ok & ~retry_left;
    assign send_done  = (~awvalid_q | m_axil.awready) & (~wvalid_q | m_axil.wready);

`ifdef BSG_IRQ_TO_AXIL_SEQ_EN
    logic [15:0] seq_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)   seq_q <= '0;
        else if (done_ok) seq_q <= seq_q + 16'd1;
    end
`endif

    for (genvar i = 0; i < irq_sources_p; i++) begin : g_src
        assign inflight_v[i] = busy & (id_q == id_w_lp'(i));
        assign clr_v[i]      = (done_ok | done_drop) & (id_q == id_w_lp'(i));
        assign hold_v[i]     = done_ok & (id_q == id_w_lp'(i)) & ~edge_mask_p[i];

        bsg_irq_pending_tracker #(
            .edge_p           (edge_mask_p[i]),
            .holdoff_cycles_p (holdoff_cycles_p)
        ) u_trk (
            .clk_i          (clk_i),
            .reset_n_i      (reset_n_i),
            .irq_i          (irq_i[i]),
            .en_i           (irq_en_i[i]),
            .in_flight_i    (inflight_v[i]),
            .clr_i          (clr_v[i]),
            .load_holdoff_i (hold_v[i]),
            .pending_o      (pending[i])
        );
    end

    // Round-robin: first pending source strictly after the last one served.
    always_comb begin
        pick_v  = 1'b0;
        pick_id = '0;
        for (int k = 1; k <= int'(irq_sources_p); k++) begin
            if (!pick_v && pending[(int'(last_q) + k) % int'(irq_sources_p)]) begin
                pick_v  = 1'b1;
                pick_id = id_w_lp'((int'(last_q) + k) % int'(irq_sources_p));
            end
        end
        pick_addr = irq_base_addr_p
                  + axil_addr_width_p'(pick_id) * axil_addr_width_p'(irq_stride_p);
        pick_data = '0;
        pick_data[id_w_lp-1:0] = pick_id;
`ifdef BSG_IRQ_TO_AXIL_SEQ_EN
        pick_data[31:16] = seq_q;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            id_q      <= '0;
            last_q    <= id_w_lp'(irq_sources_p - 1);
            retry_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            err_v_q   <= 1'b0;
            err_id_q  <= '0;
        end else begin
            err_v_q <= 1'b0;
            case (state_q)
                e_idle: begin
                    if (pick_v) begin
                        id_q      <= pick_id;
                        awaddr_q  <= pick_addr;
                        wdata_q   <= pick_data;
                        retry_q   <= '0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= e_send;
                    end
                end
                e_send: begin
                    if (awvalid_q && m_axil.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axil.wready)   wvalid_q  <= 1'b0;
                    if (send_done) begin
                        bready_q <= 1'b1;
                        state_q  <= e_resp;
                    end
                end
                e_resp: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (resp_ok) begin
                            last_q  <= id_q;
                            state_q <= e_idle;
                        end else if (retry_left) begin
                            // Resend the latched beat unchanged, including its sequence number.
                            retry_q   <= retry_q + 1'b1;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= e_send;
                        end else begin
                            last_q   <= id_q;
                            err_v_q  <= 1'b1;
                            err_id_q <= id_q;
                            state_q  <= e_idle;
                        end
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

    assign pending_o      = pending;
    assign busy_o         = busy;
    assign err_v_o        = err_v_q;
    assign err_id_o       = err_id_q;
    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = '0;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = 1'b0;
    assign m_axil.rready  = 1'b1;

    logic unused_rd;
    assign unused_rd = ^{m_axil.arready, m_axil.rvalid, m_axil.rresp, m_axil.rdata};

endmodule

// File: tb/tb_bsg_irq_to_axil_notifier.sv
// Scoreboarded bench for the interrupt-to-AXI-Lite notifier with a reactive AXI-Lite slave.
module tb_bsg_irq_to_axil_notifier;
    import bsg_irq_to_axil_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] irq = '0;
    logic [N-1:0] irq_en = '1;
    logic [N-1:0] pending;
    logic         busy, err_v;
    logic [2:0]   err_id;

    bsg_irq_to_axil_notifier_if #(.axil_addr_width_p(32), .axil_data_width_p(32)) axil ();

    bsg_irq_to_axil_notifier #(
        .axil_data_width_p (32),
        .axil_addr_width_p (32),
        .irq_sources_p     (N),
        .irq_base_addr_p   (32'h1000),
        .irq_stride_p      (4),
        .edge_mask_p       (8'h7F),
        .holdoff_cycles_p  (16),
        .max_retries_p     (3)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .irq_i     (irq),
        .irq_en_i  (irq_en),
        .pending_o (pending),
        .busy_o    (busy),
        .err_v_o   (err_v),
        .err_id_o  (err_id),
        .m_axil    (axil.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] id;
    } exp_t;

    int          vectors = 0, miscompares = 0, cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] aw_pend[$], w_pend[$];
    int          aw_cyc[$];
    int          writes = 0, b_beats = 0, aw_cnt = 0, w_cnt = 0, b_issued = 0;
    bit          b_hs_next = 1'b0;
    int          aw_stall = 0, w_stall = 0;
    logic [1:0]  resp_val = OKAY;
    logic [15:0] exp_seq = '0;
    logic [31:0] mon_a, mon_d, mon_ed;
    exp_t        mon_e;

    initial begin
        axil.awready = 1'b1; axil.wready = 1'b1;
        axil.bvalid = 1'b0;  axil.bresp = OKAY;
        axil.arready = 1'b0; axil.rvalid = 1'b0;
        axil.rdata = '0;     axil.rresp = OKAY;
    end

    // Monitor: values at the falling edge are what the next rising edge will see.
    always @(negedge clk) begin
        if (!reset_n) begin
            aw_pend.delete(); w_pend.delete();
            aw_cnt = 0; w_cnt = 0; exp_seq = '0;
        end else begin
            if (axil.awvalid && axil.awready) begin
                aw_pend.push_back(axil.awaddr); aw_cyc.push_back(cyc); aw_cnt++;
            end
            if (axil.wvalid && axil.wready) begin
                w_pend.push_back(axil.wdata); w_cnt++;
            end
            if (axil.bvalid && axil.bready) begin
                b_hs_next = 1'b1; b_beats++;
                if (!axil.bresp[1]) exp_seq++;
            end
            while (aw_pend.size() > 0 && w_pend.size() > 0) begin
                mon_a = aw_pend.pop_front();
                mon_d = w_pend.pop_front();
                writes++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mon_a, mon_d);
                end else begin
                    mon_e = exp_q.pop_front();
`ifdef BSG_IRQ_TO_AXIL_SEQ_EN
                    mon_ed = {exp_seq, mon_e.id};
`else
                    mon_ed = {16'h0, mon_e.id};
`endif
                    if (mon_a !== mon_e.addr || mon_d !== mon_ed) begin
                        miscompares++;
                        $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                                 mon_a, mon_d, mon_e.addr, mon_ed);
                    end
                end
            end
        end
    end

    // Slave responder: acts just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!reset_n) begin
            axil.bvalid = 1'b0; axil.bresp = OKAY; b_hs_next = 1'b0; b_issued = 0;
        end else begin
            if (b_hs_next) begin axil.bvalid = 1'b0; b_hs_next = 1'b0; end
            if (!axil.bvalid && aw_cnt > b_issued && w_cnt > b_issued) begin
                axil.bvalid = 1'b1; axil.bresp = resp_val; b_issued++;
            end
        end
        if (axil.awvalid && aw_stall > 0) aw_stall--;
        if (axil.wvalid && w_stall > 0) w_stall--;
        axil.awready = (aw_stall == 0);
        axil.wready  = (w_stall == 0);
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq = irq | m; tick(); tick(); irq = irq & ~m;
    endtask

    task automatic expect_write(input int id);
        exp_t e;
        e.addr = 32'h1000 + 32'(id) * 32'd4;
        e.id   = 16'(id);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && pending == '0) && n < 400) begin tick(); n++; end
        vectors++;
        if (n >= 400) begin
            miscompares++;
            $display("FAIL %s_timeout: got exp_left=%0d busy=%b pending=%h, required 0/0/00",
                     name, exp_q.size(), busy, pending);
            exp_q.delete();
        end
    endtask

    task automatic wait_awvalid(input string name);
        int n = 0;
        while (!axil.awvalid && n < 50) begin tick(); n++; end
        vectors++;
        if (!axil.awvalid) begin
            miscompares++;
            $display("FAIL %s_awvalid_timeout: got awvalid=0, required 1", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        vectors++; if (pending !== '0) begin miscompares++; $display("FAIL rst_pending: got %h, required 00", pending); end
        vectors++; if ({busy, err_v} !== 2'b00) begin miscompares++; $display("FAIL rst_busy_err: got %b, required 00", {busy, err_v}); end
        vectors++; if ({axil.awvalid, axil.wvalid, axil.bready} !== 3'b000) begin miscompares++; $display("FAIL rst_valids: got %b, required 000", {axil.awvalid, axil.wvalid, axil.bready}); end
        vectors++; if ({axil.awaddr, axil.wdata} !== 64'h0) begin miscompares++; $display("FAIL rst_addr_data: got %h, required 0", {axil.awaddr, axil.wdata}); end
        vectors++; if ({axil.arvalid, axil.rready, axil.araddr, axil.arprot} !== {1'b0, 1'b1, 32'h0, 3'h0}) begin miscompares++; $display("FAIL rst_read_tieoff: got arvalid=%b rready=%b", axil.arvalid, axil.rready); end
        reset_n = 1'b1;
        repeat (4) tick();
        vectors++; if ({busy, pending} !== 9'h0) begin miscompares++; $display("FAIL post_rst_idle: got %h, required 0", {busy, pending}); end
    endtask

    task automatic test_single_edge();
        int b0 = b_beats;
        expect_write(3);
        irq[3] = 1'b1;
        tick();
        tick();
        vectors++; if (pending !== 8'h08) begin miscompares++; $display("FAIL edge_pending: got %h, required 08", pending); end
        vectors++; if (axil.awvalid !== 1'b0) begin miscompares++; $display("FAIL edge_early_awvalid: got %b, required 0", axil.awvalid); end
        tick();
        vectors++; if ({axil.awvalid, axil.wvalid, busy} !== 3'b111) begin miscompares++; $display("FAIL edge_latency: got %b, required 111", {axil.awvalid, axil.wvalid, busy}); end
        vectors++; if (axil.wstrb !== 4'hF) begin miscompares++; $display("FAIL edge_wstrb: got %h, required F", axil.wstrb); end
        irq[3] = 1'b0;
        wait_done("edge");
        vectors++; if (b_beats - b0 !== 1) begin miscompares++; $display("FAIL edge_b_beats: got %0d, required 1", b_beats - b0); end
    endtask

    task automatic test_round_robin();
        expect_write(2);
        pulse(8'h04);
        wait_done("rr_prime");
        expect_write(5); expect_write(0); expect_write(2);
        pulse(8'h25);
        wait_done("rr");
    endtask

    task automatic test_level();
        int w0 = writes, c0 = aw_cyc.size(), n = 0;
        repeat (3) expect_write(7);
        irq[7] = 1'b1;
        while (writes < w0 + 3 && n < 300) begin tick(); n++; end
        irq[7] = 1'b0;
        wait_done("level");
        repeat (40) tick();
        vectors++; if (writes - w0 !== 3) begin miscompares++; $display("FAIL level_count: got %0d writes, required 3", writes - w0); end
        for (int k = 1; k < 3; k++) begin
            vectors++;
            if (aw_cyc.size() < c0 + 3 || aw_cyc[c0 + k] - aw_cyc[c0 + k - 1] < 19) begin
                miscompares++;
                $display("FAIL level_gap%0d: got spacing too short or missing, required >= 19 cycles", k);
            end
        end
    endtask

    task automatic test_retry();
        int w0 = writes, n = 0;
        resp_val = SLVERR;
        repeat (4) expect_write(1);
        pulse(8'h02);
        while (!err_v && n < 300) begin tick(); n++; end
        vectors++; if (err_v !== 1'b1 || err_id !== 3'd1) begin miscompares++; $display("FAIL retry_err: got v=%b id=%0d, required v=1 id=1", err_v, err_id); end
        vectors++; if (writes - w0 !== 4) begin miscompares++; $display("FAIL retry_count: got %0d writes, required 4", writes - w0); end
        vectors++; if (pending[1] !== 1'b0) begin miscompares++; $display("FAIL retry_pending: got %b, required 0", pending[1]); end
        tick();
        vectors++; if (err_v !== 1'b0) begin miscompares++; $display("FAIL retry_err_pulse: got %b, required 0", err_v); end
        resp_val = OKAY;
        wait_done("retry");
    endtask

    task automatic test_handshake();
        int b0;
        b0 = b_beats;
        aw_stall = 5; resp_val = EXOKAY;
        expect_write(4);
        pulse(8'h10);
        wait_awvalid("aw_stall");
        tick();
        vectors++; if ({axil.awvalid, axil.wvalid} !== 2'b10) begin miscompares++; $display("FAIL aw_stall_split: got aw/w=%b, required 10", {axil.awvalid, axil.wvalid}); end
        tick(); tick();
        vectors++; if (axil.awvalid !== 1'b1) begin miscompares++; $display("FAIL aw_stall_hold: got %b, required 1", axil.awvalid); end
        wait_done("aw_stall");
        vectors++; if (b_beats - b0 !== 1) begin miscompares++; $display("FAIL aw_stall_b_beats: got %0d, required 1", b_beats - b0); end
        resp_val = OKAY;
        b0 = b_beats; w_stall = 4;
        expect_write(6);
        pulse(8'h40);
        wait_awvalid("w_stall");
        tick();
        vectors++; if ({axil.awvalid, axil.wvalid} !== 2'b01) begin miscompares++; $display("FAIL w_stall_split: got aw/w=%b, required 01", {axil.awvalid, axil.wvalid}); end
        wait_done("w_stall");
        vectors++; if (b_beats - b0 !== 1) begin miscompares++; $display("FAIL w_stall_b_beats: got %0d, required 1", b_beats - b0); end
        b0 = b_beats;
        expect_write(0);
        pulse(8'h01);
        wait_awvalid("joint");
        tick();
        vectors++; if ({axil.awvalid, axil.wvalid, busy} !== 3'b001) begin miscompares++; $display("FAIL joint_hs: got aw/w/busy=%b, required 001", {axil.awvalid, axil.wvalid, busy}); end
        wait_done("joint");
        vectors++; if (b_beats - b0 !== 1) begin miscompares++; $display("FAIL joint_b_beats: got %0d, required 1", b_beats - b0); end
    endtask

    task automatic test_enable();
        int w0 = writes, n = 0;
        irq_en[5] = 1'b0;
        pulse(8'h20);
        repeat (4) tick();
        vectors++; if ({pending[5], busy} !== 2'b00) begin miscompares++; $display("FAIL en_block: got pend/busy=%b, required 00", {pending[5], busy}); end
        irq_en[5] = 1'b1;
        aw_stall = 10;
        expect_write(0);
        pulse(8'h01);
        wait_awvalid("en");
        pulse(8'h02);
        while (!pending[1] && n < 10) begin tick(); n++; end
        irq_en[1] = 1'b0;
        tick();
        vectors++; if (pending[1] !== 1'b0) begin miscompares++; $display("FAIL en_clear: got %b, required 0", pending[1]); end
        irq_en[1] = 1'b1;
        wait_done("en");
        vectors++; if (writes - w0 !== 1) begin miscompares++; $display("FAIL en_count: got %0d writes, required 1", writes - w0); end
    endtask

    task automatic test_reset_mid_send();
        int w0;
        aw_stall = 50; w_stall = 50;
        pulse(8'h40);
        wait_awvalid("rst_mid");
        w0 = writes;
        reset_n = 1'b0;
        #1;
        vectors++; if ({axil.awvalid, axil.wvalid, axil.bready, busy} !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_outputs: got %b, required 0000", {axil.awvalid, axil.wvalid, axil.bready, busy}); end
        vectors++; if (pending !== '0) begin miscompares++; $display("FAIL rst_mid_pending: got %h, required 00", pending); end
        aw_stall = 0; w_stall = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (30) tick();
        vectors++; if (writes !== w0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_quiet: got %0d new writes busy=%b, required 0/0", writes - w0, busy); end
    endtask

    task automatic test_seq();
        for (int s = 0; s < 3; s++) begin
            expect_write(s);
            pulse(8'(1 << s));
            wait_done("seq");
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_round_robin();
        test_level();
        test_retry();
        test_handshake();
        test_enable();
        test_reset_mid_send();
        test_seq();
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
